// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, IF/ID carry, resolution training and statistics signals.
interface branch_predictor_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pc_if;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            fdwrite;
    logic            ifflush;
    logic            pred_taken_id;
    logic [XLEN-1:0] pred_target_id;
    logic            upd_en;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred;
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;
    modport master (
        output pc_if, fdwrite, ifflush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        input  pred_taken, pred_target, pred_taken_id, pred_target_id, stat_branches, stat_mispred
    );
    modport slave (
        input  pc_if, fdwrite, ifflush, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        output pred_taken, pred_target, pred_taken_id, pred_target_id, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with 2-bit saturating direction counters and IF/ID prediction carry.
// Define BP_STATS_EN to build the resolved-branch and misprediction counters.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int XLEN  = 32
) (
    input logic clk,
    input logic rst_n,
    branch_predictor_if.slave bp
);
    localparam int DEPTH = 1 << IDX_W;
    logic             valid  [DEPTH];
    logic [TAG_W-1:0] tag    [DEPTH];
    logic [XLEN-1:0]  target [DEPTH];
    logic [1:0]       ctr    [DEPTH];
    logic [IDX_W-1:0] li, ui;
    logic [TAG_W-1:0] lt, ut;
    logic             uhit, unused;
    assign li = bp.pc_if[IDX_W+1:2];
    assign lt = bp.pc_if[IDX_W+TAG_W+1:IDX_W+2];
    assign ui = bp.upd_pc[IDX_W+1:2];
    assign ut = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign uhit = valid[ui] && tag[ui] == ut;
    assign unused = ^{bp.pc_if[1:0], bp.pc_if[XLEN-1:IDX_W+TAG_W+2],
                      bp.upd_pc[1:0], bp.upd_pc[XLEN-1:IDX_W+TAG_W+2], bp.upd_pred};
    // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
    assign bp.pred_taken  = valid[li] && tag[li] == lt && ctr[li][1];
    assign bp.pred_target = bp.pred_taken ? target[li] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.pred_taken_id  <= 1'b0;
            bp.pred_target_id <= '0;
        end else if (bp.ifflush) begin
            bp.pred_taken_id  <= 1'b0;
            bp.pred_target_id <= '0;
        end else if (bp.fdwrite) begin
            bp.pred_taken_id  <= bp.pred_taken;
            bp.pred_target_id <= bp.pred_target;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (bp.upd_en) begin
            if (uhit) begin
                ctr[ui] <= bp.upd_taken ? (ctr[ui] == 2'b11 ? 2'b11 : ctr[ui] + 2'd1)
                                        : (ctr[ui] == 2'b00 ? 2'b00 : ctr[ui] - 2'd1);
                if (bp.upd_taken)
                    target[ui] <= bp.upd_target;
            end else if (bp.upd_taken) begin
                valid[ui]  <= 1'b1;
                tag[ui]    <= ut;
                target[ui] <= bp.upd_target;
                ctr[ui]    <= 2'b10;
            end
        end
    end
`ifdef BP_STATS_EN
    logic [31:0] nb, nm;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb <= '0;
            nm <= '0;
        end else if (bp.upd_en) begin
            nb <= nb + {31'd0, nb != '1};
            nm <= nm + {31'd0, bp.upd_taken != bp.upd_pred && nm != '1};
        end
    end
    assign bp.stat_branches = nb;
    assign bp.stat_mispred  = nm;
`else
    assign bp.stat_branches = '0;
    assign bp.stat_mispred  = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan checks plus randomized traffic against a behavioural table model.
module tb_branch_predictor;
    localparam int IDX_W = 6, TAG_W = 8, XLEN = 32, DEPTH = 1 << IDX_W;
    logic clk = 1'b0, rst_n = 1'b0;
    bit run = 1'b0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    branch_predictor_if #(.XLEN(XLEN)) bp ();
    branch_predictor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));

    bit              mv [DEPTH];
    logic [TAG_W-1:0] mt [DEPTH];
    logic [31:0]     mg [DEPTH];
    int              mc [DEPTH];
    bit              e_tid;
    logic [31:0]     e_gid;
    longint          e_nb, e_nm;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) & 32'(DEPTH - 1));
    endfunction
    function automatic logic [TAG_W-1:0] tag_of(logic [31:0] pc);
        return TAG_W'(pc >> (IDX_W + 2));
    endfunction
    function automatic bit m_hit(logic [31:0] pc);
        return mv[idx_of(pc)] && mt[idx_of(pc)] == tag_of(pc);
    endfunction
    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && mc[idx_of(pc)] >= 2;
    endfunction
    function automatic logic [31:0] m_tgt(logic [31:0] pc);
        return m_pred(pc) ? mg[idx_of(pc)] : 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int i;
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mv[k] = 1'b0; mt[k] = '0; mg[k] = '0; mc[k] = 1;
            end
            e_tid = 1'b0; e_gid = '0; e_nb = 0; e_nm = 0;
        end else begin
            if (bp.ifflush) begin
                e_tid = 1'b0; e_gid = '0;
            end else if (bp.fdwrite) begin
                e_tid = m_pred(bp.pc_if); e_gid = m_tgt(bp.pc_if);
            end
            if (bp.upd_en) begin
                i = idx_of(bp.upd_pc);
                if (m_hit(bp.upd_pc)) begin
                    if (bp.upd_taken) begin
                        mc[i] = (mc[i] + 1 > 3) ? 3 : mc[i] + 1;
                        mg[i] = bp.upd_target;
                    end else
                        mc[i] = (mc[i] - 1 < 0) ? 0 : mc[i] - 1;
                end else if (bp.upd_taken) begin
                    mv[i] = 1'b1; mt[i] = tag_of(bp.upd_pc); mg[i] = bp.upd_target; mc[i] = 2;
                end
                if (e_nb < 64'hFFFF_FFFF) e_nb = e_nb + 1;
                if (bp.upd_taken != bp.upd_pred && e_nm < 64'hFFFF_FFFF) e_nm = e_nm + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("cmp_pred_taken", 32'(bp.pred_taken), 32'(m_pred(bp.pc_if)));
            chk("cmp_pred_target", bp.pred_target, m_tgt(bp.pc_if));
            chk("cmp_pred_taken_id", 32'(bp.pred_taken_id), 32'(e_tid));
            chk("cmp_pred_target_id", bp.pred_target_id, e_gid);
`ifdef BP_STATS_EN
            chk("cmp_stat_branches", bp.stat_branches, e_nb[31:0]);
            chk("cmp_stat_mispred", bp.stat_mispred, e_nm[31:0]);
`else
            chk("cmp_stat_branches", bp.stat_branches, 32'd0);
            chk("cmp_stat_mispred", bp.stat_mispred, 32'd0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic upd(logic [31:0] pc, logic t, logic [31:0] tg, logic p);
        bp.upd_en = 1'b1; bp.upd_pc = pc; bp.upd_taken = t; bp.upd_target = tg; bp.upd_pred = p;
    endtask
    function automatic logic [31:0] rpc();
        logic [31:0] p;
        p = $urandom;
        p[15:8] = 8'($urandom_range(0, 3));
        p[7:2] = 6'($urandom_range(0, 7));
        return p;
    endfunction

    initial begin
        bp.pc_if = '0; bp.fdwrite = 1'b0; bp.ifflush = 1'b0;
        bp.upd_en = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0; bp.upd_target = '0; bp.upd_pred = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run = 1'b1;
        bp.pc_if = 32'h40; bp.fdwrite = 1'b1; #1;
        chk("t1_pred_taken", 32'(bp.pred_taken), 32'd0);
        chk("t1_pred_target", bp.pred_target, 32'd0);
        step();
        chk("t1_pred_taken_id", 32'(bp.pred_taken_id), 32'd0);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        step();
        bp.upd_en = 1'b0; #1;
        chk("t2_pred_taken", 32'(bp.pred_taken), 32'd1);
        chk("t2_pred_target", bp.pred_target, 32'h100);
        step();
        chk("t2_pred_taken_id", 32'(bp.pred_taken_id), 32'd1);
        chk("t2_pred_target_id", bp.pred_target_id, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        repeat (3) step();
        bp.upd_taken = 1'b0;
        repeat (2) step();
        bp.upd_en = 1'b0; #1;
        chk("t3_ctr01_pred", 32'(bp.pred_taken), 32'd0);
        upd(32'h40, 1'b0, 32'h100, 1'b0);
        step();
        bp.upd_taken = 1'b1;
        step();
        bp.upd_en = 1'b0; #1;
        chk("t3_floor_then_taken_pred", 32'(bp.pred_taken), 32'd0);
        bp.upd_en = 1'b1;
        step();
        bp.upd_en = 1'b0; #1;
        chk("t3_ctr10_pred", 32'(bp.pred_taken), 32'd1);
        step();
        chk("t4_id_captured", 32'(bp.pred_taken_id), 32'd1);
        bp.fdwrite = 1'b0; bp.pc_if = 32'h80;
        step();
        step();
        chk("t4_id_held", 32'(bp.pred_taken_id), 32'd1);
        chk("t4_tgt_held", bp.pred_target_id, 32'h100);
        bp.ifflush = 1'b1;
        step();
        chk("t4_flush_wins", 32'(bp.pred_taken_id), 32'd0);
        bp.ifflush = 1'b0; bp.fdwrite = 1'b1;
        upd(32'h40 + (32'd1 << (IDX_W + 2)), 1'b1, 32'h200, 1'b0);
        step();
        bp.upd_en = 1'b0; bp.pc_if = 32'h40; #1;
        chk("t5_alias_miss", 32'(bp.pred_taken), 32'd0);
        bp.pc_if = 32'h140; #1;
        chk("t5_alias_hit", 32'(bp.pred_taken), 32'd1);
        chk("t5_alias_target", bp.pred_target, 32'h200);
        step();
        rst_n = 1'b0; #1 rst_n = 1'b1;
        upd(32'h40, 1'b1, 32'h300, 1'b1); step();
        upd(32'h40, 1'b1, 32'h300, 1'b0); step();
        upd(32'h40, 1'b0, 32'h300, 1'b0); step();
        upd(32'h40, 1'b0, 32'h300, 1'b1); step();
        upd(32'h40, 1'b1, 32'h300, 1'b1); step();
        bp.upd_en = 1'b0; #1;
`ifdef BP_STATS_EN
        chk("t6_branches", bp.stat_branches, 32'd5);
        chk("t6_mispred", bp.stat_mispred, 32'd2);
`else
        chk("t6_branches_off", bp.stat_branches, 32'd0);
        chk("t6_mispred_off", bp.stat_mispred, 32'd0);
`endif
        rst_n = 1'b0; #1;
        chk("t6_rst_branches", bp.stat_branches, 32'd0);
        chk("t6_rst_mispred", bp.stat_mispred, 32'd0);
        chk("t6_rst_taken_id", 32'(bp.pred_taken_id), 32'd0);
        chk("t6_rst_pred", 32'(bp.pred_taken), 32'd0);
        rst_n = 1'b1;
        repeat (3000) begin
            bp.pc_if = rpc();
            bp.fdwrite = $urandom_range(0, 3) != 0;
            bp.ifflush = $urandom_range(0, 9) == 0;
            bp.upd_en = $urandom_range(0, 1) == 1;
            bp.upd_pc = rpc();
            bp.upd_taken = $urandom_range(0, 2) != 0;
            bp.upd_target = $urandom & ~32'd3;
            bp.upd_pred = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; #1 rst_n = 1'b1;
            end
            step();
        end
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
